dmem_rmw_arbiter: RTL and testbench
===================================

// Module: dmem_rmw_arbiter
// PURPOSE
// Two-port arbiter and sequencer in front of the single-port data RAM (1-cycle synchronous read).
// Shares the RAM between the core load/store stage (port 0) and the program loader/debug port (port 1).
// Handles word and byte loads and stores; byte stores are done as read-modify-write.
// Byte loads are zero- or sign-extended.
// PARAMETERS
// ADDR_WIDTH  32  width of request and RAM addresses
// FIXED_PRIO  0   0 = round-robin between ports; 1 = port 0 always wins
// PORTS
// clk         in   1           system clock; all state updates on rising edge
// rst         in   1           synchronous, active-high reset
// p0_valid    in   1           port 0 request valid; held with fields stable until accepted
// p0_ready    out  1           port 0 request accepted this cycle when p0_valid & p0_ready
// p0_we       in   1           1 = store, 0 = load
// p0_byte     in   1           1 = byte access (lane = addr[1:0]), 0 = word access
// p0_sext     in   1           byte load only: 1 = sign-extend, 0 = zero-extend
// p0_addr     in   ADDR_WIDTH  byte address
// p0_wdata    in   32          store data; byte store uses wdata[7:0]
// p0_rvalid   out  1           1-cycle pulse: load data valid, or store completed
// p0_rdata    out  32          formatted load data; 0 for stores
// p1_*        --   --          identical set for port 1 (p1_valid ... p1_rdata)
// mem_we      out  1           RAM write enable
// mem_addr    out  ADDR_WIDTH  RAM address, always {addr[AW-1:2],2'b00}
// mem_wdata   out  32          RAM write data (full word)
// mem_rdata   in   32          RAM read data, valid the cycle after mem_addr is presented
// busy        out  1           1 whenever state != IDLE
// BEHAVIOUR
// - Reset values: state=IDLE; last_grant=1 (port 0 wins first); all ready/rvalid/mem_we=0.
//   rdata, mem_addr and mem_wdata reset to 0.
// - Reset mid-operation aborts the request: no rvalid, no write, and the RAM word is unchanged.
// - FSM states: IDLE, RD, MRG, WR.
// - pN_ready is asserted only in IDLE, and only for the granted port. It is combinational from the valids.
//   - Both ports valid with FIXED_PRIO=0: grant the port != last_grant.
//   - Both ports valid with FIXED_PRIO=1: grant port 0.
//   - last_grant updates on each accept.
// - On accept, latch the port id, we, byte, sext, addr and wdata. Port inputs are ignored until return to IDLE.
// - Transitions:
//   - IDLE -> WR for a word store.
//   - IDLE -> RD for any other accepted request.
// - RD: drive mem_addr with mem_we=0, then go to MRG.
// - MRG (mem_rdata valid):
//   - Word load: rdata = mem_rdata.
//   - Byte load: b = mem_rdata[8*lane+:8]; rdata = {{24{sext&b[7]}}, b}.
//   - Loads: pulse rvalid for the owning port, then go to IDLE.
//   - Byte store: register the merged word (mem_rdata with lane replaced by wdata[7:0]), then go to WR.
// - WR: mem_we=1 for exactly 1 cycle with mem_addr and mem_wdata; pulse the owner's rvalid; go to IDLE.
// - Latency from accept to rvalid:
//   - word store: 1 cycle
//   - load: 2 cycles
//   - byte store: 3 cycles
// - Back-to-back: a new accept is possible in the cycle after rvalid (IDLE). There is no pipelining.
// - Word accesses ignore addr[1:0]. rvalid is never asserted for the non-owning port.
// - Sign-extension uses bit 7 of the selected byte; sext is ignored for word loads.
// TESTING
// - Word store 0xDEADBEEF @0x10 via p0, then word load @0x10:
//   - store: rvalid 1 cycle after accept, mem_we high exactly 1 cycle.
//   - load: rdata=0xDEADBEEF, 2 cycles after accept.
// - Byte store 0xAA to 0x13 over word 0x11223344, then word load:
//   - word reads 0xAA223344.
//   - byte load @0x13 with sext=1 -> 0xFFFFFFAA; with sext=0 -> 0x000000AA.
// - Byte load @0x11 of 0x11223344 with sext=1 -> 0x00000033 (b[7]=0, so no ones extension).
// - p0 and p1 both valid continuously, FIXED_PRIO=0: grants alternate p0,p1,p0,p1.
//   Each port's rvalid and rdata are routed only to that port. With FIXED_PRIO=1, only p0 is granted.
// - Reset asserted in MRG of a byte store:
//   - next cycle: IDLE, busy=0, no rvalid, mem_we never asserted.
//   - RAM word unchanged on readback.
// - Request held while busy: ready stays 0; accept occurs the cycle after rvalid; latched fields are unaffected by input changes.

Source files
------------

// File: rtl/dmem_rmw_arbiter_if.sv
// Request/response port between one requester (core or loader) and the RAM arbiter.
// The requester holds valid and the request fields until ready is returned; rvalid/rdata is a single-cycle pulse back.
interface dmem_rmw_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic                  byte_acc;
  logic                  sext;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output valid, we, byte_acc, sext, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, byte_acc, sext, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/dmem_rmw_arbiter.sv
// Two-port arbiter/sequencer for a single-port RAM with 1-cycle read; byte stores are done as read-modify-write.
// Accept->rvalid: word store 1, load 2, byte store 3 cycles; ready only in IDLE and only for the granted port.
module dmem_rmw_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_rmw_arbiter_if.slave     p0,
  dmem_rmw_arbiter_if.slave     p1,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, RD, MRG, WR} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  byte_q, byte_d;
  logic                  sext_q, sext_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  grant_p1;
  logic                  sel_we, sel_byte, sel_sext;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [4:0]            lane_bit;
  logic [7:0]            rd_byte;
  logic [31:0]           load_fmt;
  logic [31:0]           merged;
  logic                  ready0, ready1, rvalid, mem_we;
  logic [31:0]           rdata;

  // On contention the port that did not win last time gets the grant, unless port 0 is fixed-priority.
  assign grant_p1  = (p0.valid && p1.valid) ? (FIXED_PRIO ? 1'b0 : ~last_grant_q) : p1.valid;
  assign sel_we    = grant_p1 ? p1.we       : p0.we;
  assign sel_byte  = grant_p1 ? p1.byte_acc : p0.byte_acc;
  assign sel_sext  = grant_p1 ? p1.sext     : p0.sext;
  assign sel_addr  = grant_p1 ? p1.addr     : p0.addr;
  assign sel_wdata = grant_p1 ? p1.wdata    : p0.wdata;

  assign lane_bit = {addr_q[1:0], 3'b000};
  assign rd_byte  = mem_rdata_i[lane_bit +: 8];
  assign load_fmt = byte_q ? {{24{sext_q & rd_byte[7]}}, rd_byte} : mem_rdata_i;

  always_comb begin
    merged                 = mem_rdata_i;
    merged[lane_bit +: 8]  = wdata_q[7:0];
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    byte_d       = byte_q;
    sext_d       = sext_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    ready0       = 1'b0;
    ready1       = 1'b0;
    rvalid       = 1'b0;
    rdata        = 32'h0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        ready0 = p0.valid && !grant_p1;
        ready1 = grant_p1;
        if (p0.valid || p1.valid) begin
          owner_d      = grant_p1;
          last_grant_d = grant_p1;
          we_d         = sel_we;
          byte_d       = sel_byte;
          sext_d       = sel_sext;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          state_d      = (sel_we && !sel_byte) ? WR : RD;
        end
      end
      RD: state_d = MRG;
      MRG: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rvalid  = 1'b1;
          rdata   = load_fmt;
          state_d = IDLE;
        end
      end
      WR: begin
        mem_we  = 1'b1;
        rvalid  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      sext_q       <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      byte_q       <= byte_d;
      sext_q       <= sext_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign p0.ready    = ready0;
  assign p1.ready    = ready1;
  assign p0.rvalid   = rvalid & ~owner_q;
  assign p1.rvalid   = rvalid & owner_q;
  assign p0.rdata    = owner_q ? 32'h0 : rdata;
  assign p1.rdata    = owner_q ? rdata : 32'h0;
  assign mem_we_o    = mem_we;
  assign mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_rmw_arbiter.sv
// Directed bench for dmem_rmw_arbiter: vector table of single transactions plus hand-written multi-cycle sequences.
module tb_dmem_rmw_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ram_clr;
  logic        mem_we, busy, f_mem_we, f_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] f_mem_addr, f_mem_wdata;
  logic [31:0] ram [0:63];

  dmem_rmw_arbiter_if #(.ADDR_WIDTH(32)) p0_if ();
  dmem_rmw_arbiter_if #(.ADDR_WIDTH(32)) p1_if ();
  dmem_rmw_arbiter_if #(.ADDR_WIDTH(32)) f0_if ();
  dmem_rmw_arbiter_if #(.ADDR_WIDTH(32)) f1_if ();

  dmem_rmw_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  dmem_rmw_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1'b1)) dut_fix (
    .clk(clk), .rst(rst), .p0(f0_if), .p1(f1_if),
    .mem_we_o(f_mem_we), .mem_addr_o(f_mem_addr), .mem_wdata_o(f_mem_wdata),
    .mem_rdata_i(32'h0), .busy_o(f_busy)
  );

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
    end else if (mem_we) begin
      ram[mem_addr[7:2]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[7:2]];
  end

  int we_cnt = 0;
  always @(negedge clk) if (mem_we) we_cnt++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic v, input logic we, input logic b, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    if (port == 0) begin
      p0_if.valid = v; p0_if.we = we; p0_if.byte_acc = b; p0_if.sext = s; p0_if.addr = a; p0_if.wdata = d;
    end else begin
      p1_if.valid = v; p1_if.we = we; p1_if.byte_acc = b; p1_if.sext = s; p1_if.addr = a; p1_if.wdata = d;
    end
  endtask

  task automatic do_req(input int port, input logic we, input logic b, input logic s,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output int wes);
    logic rdy, rv;
    int   w0;
    rd  = 32'h0;
    lat = -1;
    wes = -1;
    rdy = 1'b0;
    @(negedge clk);
    drive(port, 1'b1, we, b, s, a, d);
    for (int i = 0; i < 20; i++) begin
      #1;
      rdy = (port == 0) ? p0_if.ready : p1_if.ready;
      if (rdy) break;
      @(negedge clk);
    end
    if (!rdy) begin
      chk("accept_timeout", 32'd0, 32'd1);
      drive(port, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      return;
    end
    w0 = we_cnt;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) drive(port, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      rv = (port == 0) ? p0_if.rvalid : p1_if.rvalid;
      if (rv) begin
        lat = i;
        rd  = (port == 0) ? p0_if.rdata : p1_if.rdata;
        wes = we_cnt - w0;
        chk("other_port_rvalid", {31'h0, (port == 0) ? p1_if.rvalid : p0_if.rvalid}, 32'h0);
        break;
      end
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic        b;
    logic        s;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t        vt [14];
  logic [31:0] rd;
  int          lat, wes, w_snap;
  int          g_main [4];
  int          gm, gf, f1_rdy, f1_rv;

  initial begin
    vt[0]  = '{0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1};
    vt[1]  = '{0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2};
    vt[2]  = '{1, 1'b1, 1'b0, 1'b0, 32'h12, 32'h11223344, 32'h00000000, 1};
    vt[3]  = '{1, 1'b1, 1'b1, 1'b0, 32'h13, 32'h000000AA, 32'h00000000, 3};
    vt[4]  = '{0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hAA223344, 2};
    vt[5]  = '{1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0,        32'hFFFFFFAA, 2};
    vt[6]  = '{0, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0,        32'h000000AA, 2};
    vt[7]  = '{0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h11223344, 32'h00000000, 1};
    vt[8]  = '{1, 1'b0, 1'b1, 1'b1, 32'h21, 32'h0,        32'h00000033, 2};
    vt[9]  = '{0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0,        32'h00000044, 2};
    vt[10] = '{0, 1'b0, 1'b0, 1'b1, 32'h23, 32'h0,        32'h11223344, 2};
    vt[11] = '{1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h12345680, 32'h00000000, 3};
    vt[12] = '{0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0,        32'hFFFFFF80, 2};
    vt[13] = '{1, 1'b0, 1'b1, 1'b0, 32'h22, 32'h0,        32'h00000022, 2};

    rst     = 1'b1;
    ram_clr = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    f0_if.valid = 1'b0; f0_if.we = 1'b0; f0_if.byte_acc = 1'b0; f0_if.sext = 1'b0; f0_if.addr = 32'h0; f0_if.wdata = 32'h0;
    f1_if.valid = 1'b0; f1_if.we = 1'b0; f1_if.byte_acc = 1'b0; f1_if.sext = 1'b0; f1_if.addr = 32'h0; f1_if.wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    ram_clr = 1'b0;
    #1;
    chk("rst_busy",      {31'h0, busy},          32'h0);
    chk("rst_ready",     {30'h0, p1_if.ready, p0_if.ready},   32'h0);
    chk("rst_rvalid",    {30'h0, p1_if.rvalid, p0_if.rvalid}, 32'h0);
    chk("rst_mem_we",    {31'h0, mem_we},        32'h0);
    chk("rst_mem_addr",  mem_addr,               32'h0);
    chk("rst_mem_wdata", mem_wdata,              32'h0);
    chk("rst_rdata0",    p0_if.rdata,            32'h0);

    for (int i = 0; i < 14; i++) begin
      do_req(vt[i].port, vt[i].we, vt[i].b, vt[i].s, vt[i].addr, vt[i].wdata, rd, lat, wes);
      chk($sformatf("v%0d_rdata", i),   rd,  vt[i].exp_rd);
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_mem_we_cycles", i), wes, {31'h0, vt[i].we});
    end

    // Request on p1 held while p0's load is in flight.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    #1 chk("hold_p0_ready", {31'h0, p0_if.ready}, 32'h1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h34, 32'hCAFEF00D);
    #1 chk("hold_rd_p1_ready", {31'h0, p1_if.ready}, 32'h0);
    chk("hold_rd_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    #1 chk("hold_mrg_p0_rvalid", {31'h0, p0_if.rvalid}, 32'h1);
    chk("hold_mrg_p0_rdata", p0_if.rdata, 32'hAA223344);
    chk("hold_mrg_p1_ready", {31'h0, p1_if.ready}, 32'h0);
    chk("hold_mrg_p1_rvalid", {31'h0, p1_if.rvalid}, 32'h0);
    @(negedge clk);
    #1 chk("hold_idle_p1_ready", {31'h0, p1_if.ready}, 32'h1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h38, 32'h0);
    #1 chk("hold_wr_mem_we", {31'h0, mem_we}, 32'h1);
    chk("hold_wr_mem_addr", mem_addr, 32'h34);
    chk("hold_wr_mem_wdata", mem_wdata, 32'hCAFEF00D);
    chk("hold_wr_p1_rvalid", {31'h0, p1_if.rvalid}, 32'h1);
    do_req(0, 1'b0, 1'b0, 1'b0, 32'h34, 32'h0, rd, lat, wes);
    chk("hold_readback_34", rd, 32'hCAFEF00D);
    do_req(0, 1'b0, 1'b0, 1'b0, 32'h38, 32'h0, rd, lat, wes);
    chk("hold_readback_38", rd, 32'h0);

    // Reset while a byte store sits in MRG.
    w_snap = we_cnt;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12, 32'h55);
    #1 chk("rstmid_accept", {31'h0, p0_if.ready}, 32'h1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1 chk("rstmid_busy_mrg", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_rvalid", {31'h0, p0_if.rvalid}, 32'h0);
    chk("rstmid_mem_we", {31'h0, mem_we}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("rstmid_no_write", we_cnt - w_snap, 32'h0);
    do_req(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rd, lat, wes);
    chk("rstmid_readback", rd, 32'hAA223344);

    // Both ports requesting continuously on both arbiter variants.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gm = 0; gf = 0; f1_rdy = 0; f1_rv = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) begin
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        f0_if.valid = 1'b1; f0_if.addr = 32'h10;
        f1_if.valid = 1'b1; f1_if.addr = 32'h20;
      end
      if (gm >= 4) begin
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (gf >= 4) begin
        f0_if.valid = 1'b0;
        f1_if.valid = 1'b0;
      end
      #1;
      if (p0_if.ready && gm < 4) begin g_main[gm] = 0; gm++; end
      if (p1_if.ready && gm < 4) begin g_main[gm] = 1; gm++; end
      if (p0_if.rvalid) begin
        chk("arb_p0_rdata", p0_if.rdata, 32'hAA223344);
        chk("arb_p0_exclusive", {31'h0, p1_if.rvalid}, 32'h0);
      end
      if (p1_if.rvalid) chk("arb_p1_rdata", p1_if.rdata, 32'h11223380);
      if (f0_if.ready && gf < 4) gf++;
      if (f1_if.ready) f1_rdy++;
      if (f1_if.rvalid) f1_rv++;
    end
    chk("arb_grant_count", gm, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb_grant_%0d", i), g_main[i], i % 2);
    chk("fix_p0_grants", gf, 32'd4);
    chk("fix_p1_ready", f1_rdy, 32'd0);
    chk("fix_p1_rvalid", f1_rv, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
